// File: rtl/fetch_pkg.sv
// Shared fetch types: word geometry and the {inst, pc} entry handed to decode.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with clear; head is read from registered storage.
module fetch_queue_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

    // Next-state for storage, pointers and occupancy; clear wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order buffering, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(INST_BYTES);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    head_entry_s;
    fetch_entry_t    push_entry_s;
    logic            push_s, pop_s, bypass_s, rsp_keep_s, req_fire_s, credit_ok_s;
    logic [CW-1:0]   req_one_s, rsp_one_s;

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head_entry (head_entry_s),
        .count      (fifo_count_s)
    );

    // Handshakes, FIFO control and decode-side outputs.
    always_comb begin
        // Queued plus in-flight words never exceed DEPTH, so a response always has a slot.
        credit_ok_s    = ({1'b0, fifo_count_s} + {1'b0, outstanding_q}) < DEPTH_C;
        imem_req_valid = rst & ~redirect_valid & credit_ok_s;
        imem_req_addr  = fetch_pc_q;
        req_fire_s     = imem_req_valid & imem_req_ready;
        req_one_s      = {{(CW-1){1'b0}}, req_fire_s};
        rsp_one_s      = {{(CW-1){1'b0}}, imem_rsp_valid};
        rsp_keep_s     = rst & imem_rsp_valid & ~redirect_valid & (discard_q == {CW{1'b0}});
        push_entry_s   = '{inst: imem_rsp_data, pc: rsp_pc_q};
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s  = rsp_keep_s & (fifo_count_s == {CW{1'b0}});
        dec_valid = rst & ~redirect_valid & ((fifo_count_s != {CW{1'b0}}) | bypass_s);
        if (bypass_s) begin
            dec_inst = imem_rsp_data;
            dec_pc   = rsp_pc_q;
        end else begin
            dec_inst = head_entry_s.inst;
            dec_pc   = head_entry_s.pc;
        end
`else
        bypass_s  = 1'b0;
        dec_valid = rst & ~redirect_valid & (fifo_count_s != {CW{1'b0}});
        dec_inst  = head_entry_s.inst;
        dec_pc    = head_entry_s.pc;
`endif
        pop_s  = dec_valid & dec_ready & ~bypass_s;
        push_s = rsp_keep_s & ~(bypass_s & dec_ready);
    end

    // PC, credit and discard bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            // Everything still in flight, minus a beat landing now, belongs to the old path.
            fetch_pc_d    = align_pc(redirect_pc);
            rsp_pc_d      = align_pc(redirect_pc);
            outstanding_d = outstanding_q - rsp_one_s;
            discard_d     = outstanding_q - rsp_one_s;
        end else begin
            outstanding_d = outstanding_q + req_one_s - rsp_one_s;
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + STEP_C;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rsp_valid && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - CW'(1);
            end else if (imem_rsp_valid) begin
                rsp_pc_d = rsp_pc_q + STEP_C;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table, directed corner sequences, random run vs a queue model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] addr; int epoch; int due; } memreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct {
        bit redir; logic [31:0] rpc;
        bit e_rv; logic [31:0] e_addr; bit e_dv; logic [31:0] e_pc;
    } vec_t;

    memreq_t     q_mem[$];
    ent_t        q_dec[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc;
    int          epoch, cyc, fires, lat_lo, lat_hi;
    int          checks, errors;
    bit          in_rst, in_redir, in_req_ready, in_dec_ready;
    logic [31:0] in_rpc;
    bit          s_rv, s_dv;
    logic [31:0] s_addr, s_pc, s_inst;
    vec_t        tbl[8];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0050_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs and memory response, sample, compare with the model, advance the model.
    task automatic step();
        memreq_t     r;
        ent_t        e;
        bit          rsp_v, fresh, byp, exp_rv, exp_dv;
        logic [31:0] data;
        @(negedge clk);
        rst            = in_rst;
        redirect_valid = in_redir;
        redirect_pc    = in_rpc;
        imem_req_ready = in_req_ready;
        dec_ready      = in_dec_ready;
        rsp_v = in_rst && (q_mem.size() > 0) && (q_mem[0].due <= cyc);
        data  = rsp_v ? inst_of(q_mem[0].addr) : $urandom;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = data;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_dv = dec_valid; s_pc = dec_pc; s_inst = dec_inst;
        fresh  = rsp_v && !in_redir && (q_mem[0].epoch == epoch);
        byp    = BYP && fresh && (q_dec.size() == 0);
        exp_rv = in_rst && !in_redir && ((q_dec.size() + q_mem.size()) < DEPTH);
        exp_dv = in_rst && !in_redir && ((q_dec.size() > 0) || byp);
        chk("req_valid", {31'd0, s_rv}, {31'd0, exp_rv});
        if (exp_rv && s_rv) chk("req_addr", s_addr, m_fetch_pc);
        chk("dec_valid", {31'd0, s_dv}, {31'd0, exp_dv});
        if (exp_dv && s_dv) begin
            if (byp) e = '{q_mem[0].addr, data};
            else     e = q_dec[0];
            chk("dec_pc", s_pc, e.pc);
            chk("dec_inst", s_inst, e.inst);
        end
        if (!in_rst) begin
            q_mem.delete(); q_dec.delete();
            m_fetch_pc = 32'h0; epoch++;
        end else begin
            if (rsp_v) r = q_mem.pop_front();
            if (in_redir) begin
                q_dec.delete(); epoch++;
                m_fetch_pc = in_rpc & 32'hFFFF_FFFC;
            end else begin
                if (exp_dv && in_dec_ready) begin
                    if (byp) pop_log.push_back(r.addr);
                    else begin e = q_dec.pop_front(); pop_log.push_back(e.pc); end
                end
                if (fresh && !(byp && in_dec_ready)) q_dec.push_back('{r.addr, data});
                if (exp_rv && in_req_ready) begin
                    q_mem.push_back('{m_fetch_pc, epoch, cyc + $urandom_range(lat_hi, lat_lo)});
                    m_fetch_pc += 32'd4;
                    fires++;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int lat);
        in_rst = 1'b0; in_redir = 1'b0; in_rpc = 32'h0;
        in_req_ready = 1'b1; in_dec_ready = 1'b1;
        lat_lo = lat; lat_hi = lat;
        repeat (2) step();
        in_rst = 1'b1;
        fires = 0;
        pop_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit found;
        int n0;
        checks = 0; errors = 0; cyc = 0; epoch = 0; m_fetch_pc = 32'h0;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; dec_ready = 1'b0;

        // Cycle table from the first rst=1 cycle, 1-cycle memory, everything ready.
        tbl[0] = '{1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'h203, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        if (BYP) begin
            tbl[1] = '{1'b0, 32'h0, 1'b1, 32'h4,   1'b1, 32'h0};
            tbl[2] = '{1'b0, 32'h0, 1'b1, 32'h8,   1'b1, 32'h4};
            tbl[3] = '{1'b0, 32'h0, 1'b1, 32'hC,   1'b1, 32'h8};
            tbl[6] = '{1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h200};
            tbl[7] = '{1'b0, 32'h0, 1'b1, 32'h208, 1'b1, 32'h204};
        end else begin
            tbl[1] = '{1'b0, 32'h0, 1'b1, 32'h4,   1'b0, 32'h0};
            tbl[2] = '{1'b0, 32'h0, 1'b1, 32'h8,   1'b1, 32'h0};
            tbl[3] = '{1'b0, 32'h0, 1'b1, 32'hC,   1'b1, 32'h4};
            tbl[6] = '{1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0};
            tbl[7] = '{1'b0, 32'h0, 1'b1, 32'h208, 1'b1, 32'h200};
        end

        do_reset(1);
        chk("reset_req_valid", {31'd0, s_rv}, 32'd0);
        chk("reset_dec_valid", {31'd0, s_dv}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            in_redir = tbl[i].redir; in_rpc = tbl[i].rpc;
            step();
            chk("tbl_req_valid", {31'd0, s_rv}, {31'd0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk("tbl_req_addr", s_addr, tbl[i].e_addr);
            chk("tbl_dec_valid", {31'd0, s_dv}, {31'd0, tbl[i].e_dv});
            if (tbl[i].e_dv) begin
                chk("tbl_dec_pc", s_pc, tbl[i].e_pc);
                chk("tbl_dec_inst", s_inst, inst_of(tbl[i].e_pc));
            end
        end
        in_redir = 1'b0;

        // Full queue with decode stalled: exactly DEPTH requests, then drain in order.
        do_reset(1);
        in_dec_ready = 1'b0;
        repeat (10) step();
        chk("fill_requests", fires, DEPTH);
        chk("fill_req_valid", {31'd0, s_rv}, 32'd0);
        in_dec_ready = 1'b1;
        for (int k = 0; k < 20 && pop_log.size() < 4; k++) step();
        chk("drain_count", pop_log.size() >= 4 ? 32'd4 : pop_log.size(), 32'd4);
        for (int k = 0; k < 4 && k < pop_log.size(); k++) chk("drain_pc", pop_log[k], k * 4);
        repeat (3) step();
        chk("issue_resumes", {31'd0, fires > DEPTH}, 32'd1);

        // Sustained throughput with a 1-cycle memory.
        do_reset(1);
        repeat (6) step();
        n0 = pop_log.size();
        repeat (10) step();
        chk("throughput", pop_log.size() - n0, 32'd10);

        // 3-cycle memory, three in flight, redirect to 0x100.
        do_reset(3);
        repeat (3) step();
        in_redir = 1'b1; in_rpc = 32'h100;
        step();
        in_redir = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (s_dv) begin
                found = 1'b1;
                chk("redir3_first_pc", s_pc, 32'h100);
                chk("redir3_first_inst", s_inst, inst_of(32'h100));
            end
        end
        chk("redir3_dec_seen", {31'd0, found}, 32'd1);

        // Redirect with two queued entries and a response landing in the same cycle.
        do_reset(1);
        in_dec_ready = 1'b0;
        repeat (3) step();
        in_redir = 1'b1; in_rpc = 32'h300;
        step();
        chk("redir_cnt2_dec_valid", {31'd0, s_dv}, 32'd0);
        in_redir = 1'b0;
        step();
        chk("post_redir_dec_valid", {31'd0, s_dv}, 32'd0);
        chk("post_redir_req_addr", s_addr, 32'h300);
        in_dec_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_dv) begin
                found = 1'b1;
                chk("redir_cnt2_first_pc", s_pc, 32'h300);
            end
        end
        chk("redir_cnt2_dec_seen", {31'd0, found}, 32'd1);

        // Random traffic against the queue model.
        do_reset(1);
        lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 3000; k++) begin
            in_rst       = ($urandom_range(0, 199) != 0);
            in_redir     = ($urandom_range(0, 19) == 0);
            in_rpc       = $urandom;
            in_req_ready = ($urandom_range(0, 3) != 0);
            in_dec_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between instruction memory and the decode stage. Issues sequential word fetches to a variable-latency instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Presents them to decode over a valid/ready channel. A branch redirect flushes the queue and discards in-flight responses, then refetches from the target.

## Interface
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- redirect_valid  in  1  taken branch or jump; flush and restart
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response beat; in order, one per accepted request
- imem_rsp_data  in  32  instruction word
- dec_valid  out  1  head entry available
- dec_ready  in  1  decode consumes head
- dec_inst  out  32  head instruction
- dec_pc  out  32  PC of head instruction

## Operation
- State: fetch_pc, rsp_pc, FIFO (count, rd/wr pointers), outstanding (0..DEPTH), discard (0..DEPTH).
- Reset (rst=0 at posedge): fetch_pc=rsp_pc=RESET_PC, count=0, outstanding=0, discard=0. While rst=0, imem_req_valid=0 and dec_valid=0. dec_inst/dec_pc are don't-care when dec_valid=0.
- Issue: imem_req_valid = rst & ~redirect_valid & (count+outstanding < DEPTH). imem_req_addr = fetch_pc. Request fires on valid&ready: fetch_pc += 4 (mod 2^32), outstanding++.
- Response: outstanding-- on every rsp beat. If discard>0, drop the beat and decrement discard. Otherwise write {imem_rsp_data, rsp_pc} to the FIFO and advance rsp_pc by 4.
- The credit rule guarantees a response never finds the FIFO full; no overflow path exists.
- Pop: dec_valid = (count>0) & ~redirect_valid. A pop fires on dec_valid&dec_ready. Push and pop in the same cycle leave count unchanged.
- Redirect cycle:
  - FIFO is cleared and fetch_pc=rsp_pc={redirect_pc[31:2],2'b00}.
  - discard = outstanding − imem_rsp_valid. A response arriving in the redirect cycle is dropped.
  - No request issues and no pop fires.
- Redirects on consecutive cycles are legal. Each one recomputes discard from the current outstanding count.
- Pointers wrap modulo DEPTH. PCs wrap modulo 2^32.

## Timing
- First request: the first cycle with rst=1.
- Throughput: one instruction per cycle sustained with a 1-cycle-latency memory and dec_ready held high.
- Response to dec_valid: 1 cycle (registered FIFO) without bypass; see Configuration.
- Redirect to first refetch request: 1 cycle. No stale instruction ever reaches decode after a redirect.
- Reset asserted mid-operation overrides redirect and all handshakes in that cycle. Memory responses to pre-reset requests are the memory's responsibility (the memory is reset in the same cycle).

## Configuration
- FETCH_QUEUE_BYPASS_EN defined, with FIFO empty, a non-discarded response, and no redirect:
  - dec_valid=1 in the same cycle, with dec_inst=imem_rsp_data and dec_pc=rsp_pc.
  - If dec_ready=1, the word bypasses the FIFO (no write). Otherwise it is written normally.
- FETCH_QUEUE_BYPASS_EN undefined: dec outputs come only from FIFO storage, giving 1-cycle minimum latency. No combinational path runs from imem_rsp_* to dec_*.

## Structure
- fetch_pkg: XLEN=32, INST_BYTES=4, and the fetch entry struct {inst, pc}. Shared with decode.
- Sub-module fetch_queue_fifo: DEPTH-entry synchronous FIFO of fetch entries with push, pop, clear, count, and head outputs. The top holds the PC, credit and discard logic.

## Test plan
- Reset release, 1-cycle memory, dec_ready=1 → requests 0x0, 0x4, 0x8…; decode sees pc 0x0, 0x4, 0x8 on consecutive cycles with matching words.
- dec_ready=0 with DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0. Raising dec_ready drains 4 entries in order and issue resumes.
- 3-cycle memory latency with 3 outstanding, redirect to 0x100 → the 3 stale responses are dropped; the next dec_pc is 0x100 with the word fetched from 0x100.
- Redirect in the same cycle as a response and with count=2 → dec_valid=0 that cycle, both entries and the response discarded, and discard = outstanding−1.
- redirect_pc=0x203 → imem_req_addr=0x200 and dec_pc=0x200.
- FETCH_QUEUE_BYPASS_EN on vs off, empty queue, response of 0x00500113 at cycle N → dec_valid at N (on) vs N+1 (off).
